// File: rtl/gpu_cmd_dispatch.sv
// Command FIFO and sequencer between the APB GPU command slave and the raster engine.
// Setter opcodes update shadow state; draw opcodes run a start/done handshake.
module gpu_cmd_dispatch #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        command_i,
    input  logic [3:0]  opcode_i,
    input  logic [24:0] parameters_i,
    input  logic        done_i,
    output logic        start_o,
    output logic [1:0]  op_o,
    output logic [9:0]  x0_o,
    output logic [9:0]  y0_o,
    output logic [9:0]  x1_o,
    output logic [9:0]  y1_o,
    output logic [23:0] color_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic        bad_op_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DECODE, START, WAIT} state_t;

    state_t          state, state_nxt;
    logic [28:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic [28:0]     cmd;
    logic            full, empty, push, pop;

    logic [23:0]     sh_color, sh_color_nxt;
    logic [9:0]      p0x, p0y, p1x, p1y;
    logic [9:0]      p0x_nxt, p0y_nxt, p1x_nxt, p1y_nxt;
    logic            start_nxt, busy_nxt, overflow_nxt, bad_op_nxt;
    logic [1:0]      op_nxt;
    logic [9:0]      x0_nxt, y0_nxt, x1_nxt, y1_nxt;
    logic [23:0]     color_nxt;

    logic [3:0]      cmd_op;
    logic [24:0]     cmd_param;
    logic            unused_param_bit;

    assign cmd_op           = cmd[28:25];
    assign cmd_param        = cmd[24:0];
    assign unused_param_bit = cmd_param[24];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO drops the strobe even if a pop frees a slot this cycle.
    assign push  = command_i && !full;
    assign pop   = (state == IDLE) && !empty;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {opcode_i, parameters_i};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cmd    <= '0;
        end else begin
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cmd    <= mem[rd_ptr];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!empty) state_nxt = DECODE;
            DECODE: state_nxt = (cmd_op inside {4'd4, 4'd5, 4'd6}) ? START : IDLE;
            START:  state_nxt = WAIT;
            WAIT:   if (done_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / shadow next-value logic; everything is registered below.
    always_comb begin
        sh_color_nxt = sh_color;
        p0x_nxt      = p0x;
        p0y_nxt      = p0y;
        p1x_nxt      = p1x;
        p1y_nxt      = p1y;
        op_nxt       = op_o;
        x0_nxt       = x0_o;
        y0_nxt       = y0_o;
        x1_nxt       = x1_o;
        y1_nxt       = y1_o;
        color_nxt    = color_o;
        overflow_nxt = overflow_o || (command_i && full);
        bad_op_nxt   = bad_op_o;
        if (state == DECODE) begin
            case (cmd_op)
                4'd0: ;
                4'd1: sh_color_nxt = cmd_param[23:0];
                4'd2: begin
                    p0x_nxt = cmd_param[19:10];
                    p0y_nxt = cmd_param[9:0];
                end
                4'd3: begin
                    p1x_nxt = cmd_param[19:10];
                    p1y_nxt = cmd_param[9:0];
                end
                4'd4: begin
                    op_nxt    = 2'd0;
                    x0_nxt    = p0x;
                    y0_nxt    = p0y;
                    x1_nxt    = p1x;
                    y1_nxt    = p1y;
                    color_nxt = sh_color;
                end
                4'd5: begin
                    op_nxt    = 2'd1;
                    x0_nxt    = (p0x < p1x) ? p0x : p1x;
                    x1_nxt    = (p0x < p1x) ? p1x : p0x;
                    y0_nxt    = (p0y < p1y) ? p0y : p1y;
                    y1_nxt    = (p0y < p1y) ? p1y : p0y;
                    color_nxt = sh_color;
                end
                4'd6: begin
                    op_nxt    = 2'd2;
                    x0_nxt    = 10'd0;
                    y0_nxt    = 10'd0;
                    x1_nxt    = 10'd639;
                    y1_nxt    = 10'd479;
                    color_nxt = sh_color;
                end
                default: bad_op_nxt = 1'b1;
            endcase
        end
        start_nxt = (state_nxt == START);
        busy_nxt  = (count_nxt != '0) || (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sh_color   <= '0;
            p0x        <= '0;
            p0y        <= '0;
            p1x        <= '0;
            p1y        <= '0;
            start_o    <= 1'b0;
            op_o       <= '0;
            x0_o       <= '0;
            y0_o       <= '0;
            x1_o       <= '0;
            y1_o       <= '0;
            color_o    <= '0;
            busy_o     <= 1'b0;
            overflow_o <= 1'b0;
            bad_op_o   <= 1'b0;
        end else begin
            sh_color   <= sh_color_nxt;
            p0x        <= p0x_nxt;
            p0y        <= p0y_nxt;
            p1x        <= p1x_nxt;
            p1y        <= p1y_nxt;
            start_o    <= start_nxt;
            op_o       <= op_nxt;
            x0_o       <= x0_nxt;
            y0_o       <= y0_nxt;
            x1_o       <= x1_nxt;
            y1_o       <= y1_nxt;
            color_o    <= color_nxt;
            busy_o     <= busy_nxt;
            overflow_o <= overflow_nxt;
            bad_op_o   <= bad_op_nxt;
        end
    end
endmodule

// File: doc/gpu_cmd_dispatch.md
Name: gpu_cmd_dispatch

Overview:
- Sits directly downstream of the APB GPU command slave.
- Consumes its single-cycle command strobe, 4-bit opcode and 25-bit parameter word, and queues them in a small FIFO.
- Executes the queued commands in order: state-setting opcodes update shadow registers; draw opcodes issue a start/done handshake to the raster engine.
- Decouples bus write bursts from raster-engine latency.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two, 2..64); each entry is 29 bits ({opcode, parameters}).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- command_i  input  1  one-cycle strobe: opcode_i/parameters_i valid this cycle
- opcode_i  input  4  command opcode
- parameters_i  input  25  command parameters
- done_i  input  1  raster engine finished current draw (single-cycle pulse)
- start_o  output  1  one-cycle draw start pulse to raster engine
- op_o  output  2  draw operation: 0 line, 1 rect fill, 2 clear
- x0_o  output  10  draw start x
- y0_o  output  10  draw start y
- x1_o  output  10  draw end x
- y1_o  output  10  draw end y
- color_o  output  24  draw colour, RGB888
- busy_o  output  1  FIFO non-empty or state not IDLE
- overflow_o  output  1  sticky: a command was dropped because the FIFO was full
- bad_op_o  output  1  sticky: an undefined opcode was popped

Behaviour:
- Interface: one clock `clk`; reset `n_rst` is asynchronous, active-low. All outputs and state are registered.
- Reset values: all outputs 0; FIFO empty; shadow registers (colour, P0, P1) 0; state IDLE.
- Reset asserted mid-operation clears everything immediately, including an in-flight draw. The raster engine is reset by the same `n_rst`.
- Push: on `command_i`=1 with count<DEPTH, write {opcode_i, parameters_i} at the write pointer; pointer increments and wraps modulo DEPTH.
- Overflow: on `command_i`=1 with count==DEPTH, drop the entry and set `overflow_o`. This applies even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): both happen; count unchanged.
- Opcode map:
  - 0 NOP
  - 1 SET_COLOR: colour <= param[23:0]
  - 2 SET_P0: x <= param[19:10], y <= param[9:0]
  - 3 SET_P1: same field mapping as SET_P0
  - 4 DRAW_LINE
  - 5 FILL_RECT
  - 6 CLEAR
  - 7-15: undefined; discarded and set `bad_op_o`.
- Parameter bit 24 is ignored for all opcodes.
- State machine:
  - IDLE: if FIFO non-empty, pop head into the command register and go to DECODE.
  - DECODE:
    - NOP, setter or undefined opcode: apply effect at this clock edge and go to IDLE.
    - Draw opcode: load outputs from the shadow registers, go to START.
  - START: `start_o`=1 for exactly this cycle; go to WAIT. `done_i` is ignored in START.
  - WAIT: hold all draw outputs stable; when `done_i`=1, go to IDLE.
- Draw output rules:
  - DRAW_LINE: outputs are P0→P1 as stored.
  - FILL_RECT: normalise so that x0_o=min(x), x1_o=max(x), y0_o=min(y), y1_o=max(y).
  - CLEAR: x0=y0=0, x1=639, y1=479; colour from the shadow register.
- Latency: command strobed at edge N → popped at N+1.
  - Setter takes effect at N+2.
  - Draw: `start_o` high in the cycle following edge N+2.
- Throughput: setter 2 cycles per command; draw 3 cycles plus raster time.
- Shadow registers change only in DECODE, so a queued setter never alters an active draw.
- Draw outputs hold their last values after completion until the next draw loads.
- `busy_o` = (count≠0) or (state≠IDLE), registered-equivalent.
- Sticky flags clear only on reset.

Test Plan:
- Reset then SET_COLOR 0x00FF00, SET_P0 (10,20), SET_P1 (100,200), DRAW_LINE on back-to-back cycles → a single `start_o`; op_o=0, x0=10, y0=20, x1=100, y1=200, color_o=0x00FF00; `busy_o` stays high until `done_i` pulses, then falls.
- SET_P0 (300,50), SET_P1 (20,400), FILL_RECT → op_o=1, x0=20, y0=50, x1=300, y1=400.
- Queue DRAW_LINE followed by SET_COLOR 0xFF0000 while `done_i` is withheld 20 cycles → color_o stays at the old colour throughout WAIT. The next CLEAR outputs 0xFF0000 with (0,0)-(639,479).
- Nine strobes in 9 consecutive cycles with DEPTH=8 while a draw is stalled → `overflow_o`=1; exactly 8 commands execute in order after `done_i`.
- Opcode 0xB with any parameter → no `start_o`, `bad_op_o`=1, shadow registers unchanged.
- Assert `n_rst` during WAIT with 3 entries queued → all outputs 0 and state IDLE. After release, no `start_o` occurs until a new command arrives.
